// File: rtl/lock_pkg.sv
// Shared definitions for the parametrised lock core: state encoding and
// counter-width helper.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_OPEN    = 3'd1,
    ST_SET_PW  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  localparam int STATE_W = 3;

  // Bits needed to hold every value 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/security_lock_core_param_lockout_timer.sv
// Loadable down-counter for the lockout period; o_done marks the last
// counted cycle so the owner can leave lockout on the same edge it expires.
module lockout_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_remaining,
  output logic         o_done
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_remaining <= '0;
    end else if (i_load) begin
      o_remaining <= i_value;
    end else if (o_remaining != '0) begin
      o_remaining <= o_remaining - 1'b1;
    end
  end

  assign o_done = (o_remaining == W'(1));

endmodule

// File: rtl/security_lock_core_param.sv
// Lock core: digit entry buffer, stored password, trial counting, timed
// lockout, in-service password change and a terminal alarm.
module security_lock_core_param
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 3,
  parameter int MAX_TRIALS     = 3,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter int MAX_LOCKOUTS   = 3,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_PASSWORD = '0,
  localparam int PW_W    = NUM_DIGITS * DIGIT_W,
  localparam int TRIAL_W = $clog2(MAX_TRIALS + 1),
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1),
  localparam int LO_W    = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DIGIT_W-1:0]   i_digit,
  input  logic                 i_digit_valid,
  input  logic                 i_confirm,
  input  logic                 i_switch,
  input  logic                 i_clear,
  output logic [STATE_W-1:0]   o_state,
  output logic                 o_correct,
  output logic                 o_incorrect,
  output logic [TRIAL_W-1:0]   o_trials_left,
  output logic [PW_W-1:0]      o_entry,
  output logic [CNT_W-1:0]     o_entry_count,
  output logic [LO_W-1:0]      o_lockout_remaining
);

  localparam int LC_W = cnt_w(MAX_LOCKOUTS);

  state_t              state_q, state_d;
  logic [PW_W-1:0]     entry_q, entry_d;
  logic [PW_W-1:0]     pw_q, pw_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TRIAL_W-1:0]  trials_q, trials_d;
  logic [LC_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                incorrect_q, incorrect_d;
  logic                timer_load, timer_done;
  logic [LO_W-1:0]     timer_rem;
  logic                entry_full;
  logic [PW_W-1:0]     entry_shift;
  logic [CNT_W-1:0]    count_inc;

  lockout_timer #(.W(LO_W)) u_lockout_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (timer_load),
    .i_value     (LO_W'(LOCKOUT_CYCLES)),
    .o_remaining (timer_rem),
    .o_done      (timer_done)
  );

  // Oldest digit falls off the top once the buffer is full.
  assign entry_full  = (count_q == CNT_W'(NUM_DIGITS));
  assign entry_shift = PW_W'({entry_q, i_digit});
  assign count_inc   = entry_full ? count_q : count_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_LOCKED;
      entry_q     <= '0;
      pw_q        <= RESET_PASSWORD;
      count_q     <= '0;
      trials_q    <= TRIAL_W'(MAX_TRIALS);
      lock_cnt_q  <= '0;
      incorrect_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      pw_q        <= pw_d;
      count_q     <= count_d;
      trials_q    <= trials_d;
      lock_cnt_q  <= lock_cnt_d;
      incorrect_q <= incorrect_d;
    end
  end

  // Input priority within a cycle: clear > confirm > switch > digit.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    pw_d        = pw_q;
    count_d     = count_q;
    trials_d    = trials_q;
    lock_cnt_d  = lock_cnt_q;
    incorrect_d = incorrect_q;
    timer_load  = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (i_clear) begin
          entry_d     = '0;
          count_d     = '0;
          incorrect_d = 1'b0;
        end else if (i_confirm) begin
          if (entry_full) begin
            entry_d = '0;
            count_d = '0;
            if (entry_q == pw_q) begin
              state_d     = ST_OPEN;
              trials_d    = TRIAL_W'(MAX_TRIALS);
              lock_cnt_d  = '0;
              incorrect_d = 1'b0;
            end else begin
              trials_d    = trials_q - 1'b1;
              incorrect_d = 1'b1;
              if (trials_q == TRIAL_W'(1)) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (lock_cnt_q == LC_W'(MAX_LOCKOUTS - 1)) begin
                  state_d = ST_ALARM;
                end else begin
                  state_d    = ST_LOCKOUT;
                  timer_load = 1'b1;
                end
              end
            end
          end
        end else if (!i_switch && i_digit_valid) begin
          entry_d     = entry_shift;
          count_d     = count_inc;
          incorrect_d = 1'b0;
        end
      end
      ST_OPEN: begin
        if (i_clear) begin
          entry_d = '0;
          count_d = '0;
        end else if (i_confirm) begin
          state_d = ST_LOCKED;
          entry_d = '0;
          count_d = '0;
        end else if (i_switch) begin
          state_d = ST_SET_PW;
          entry_d = '0;
          count_d = '0;
        end
      end
      ST_SET_PW: begin
        if (i_clear) begin
          entry_d = '0;
          count_d = '0;
        end else if (i_confirm) begin
          if (entry_full) begin
            pw_d    = entry_q;
            state_d = ST_OPEN;
            entry_d = '0;
            count_d = '0;
          end
        end else if (i_switch) begin
          state_d = ST_OPEN;
          entry_d = '0;
          count_d = '0;
        end else if (i_digit_valid) begin
          entry_d = entry_shift;
          count_d = count_inc;
        end
      end
      ST_LOCKOUT: begin
        if (timer_done) begin
          state_d  = ST_LOCKED;
          trials_d = TRIAL_W'(MAX_TRIALS);
        end
      end
      ST_ALARM: begin
        trials_d    = '0;
        incorrect_d = 1'b1;
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_comb begin
    o_state             = state_q;
    o_correct           = (state_q == ST_OPEN) || (state_q == ST_SET_PW);
    o_incorrect         = incorrect_q;
    o_trials_left       = trials_q;
    o_entry             = entry_q;
    o_entry_count       = count_q;
    o_lockout_remaining = timer_rem;
  end

endmodule

// File: tb/tb_security_lock_core_param.sv
// Scenario bench for security_lock_core_param: each task queues per-cycle
// stimulus with its expected registered outputs and checks them after the edge.
module tb_security_lock_core_param;

  localparam int DIGIT_W        = 4;
  localparam int NUM_DIGITS     = 3;
  localparam int MAX_TRIALS     = 3;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int MAX_LOCKOUTS   = 2;
  localparam logic [11:0] RESET_PASSWORD = 12'h123;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0;
  logic [3:0]   i_digit = '0;
  logic         i_digit_valid = 1'b0;
  logic         i_confirm = 1'b0;
  logic         i_switch = 1'b0;
  logic         i_clear = 1'b0;
  logic [2:0]   o_state;
  logic         o_correct;
  logic         o_incorrect;
  logic [1:0]   o_trials_left;
  logic [11:0]  o_entry;
  logic [1:0]   o_entry_count;
  logic [3:0]   o_lockout_remaining;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  security_lock_core_param #(
    .DIGIT_W        (DIGIT_W),
    .NUM_DIGITS     (NUM_DIGITS),
    .MAX_TRIALS     (MAX_TRIALS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .MAX_LOCKOUTS   (MAX_LOCKOUTS),
    .RESET_PASSWORD (RESET_PASSWORD)
  ) dut (
    .i_clk               (clk),
    .i_reset             (i_reset),
    .i_digit             (i_digit),
    .i_digit_valid       (i_digit_valid),
    .i_confirm           (i_confirm),
    .i_switch            (i_switch),
    .i_clear             (i_clear),
    .o_state             (o_state),
    .o_correct           (o_correct),
    .o_incorrect         (o_incorrect),
    .o_trials_left       (o_trials_left),
    .o_entry             (o_entry),
    .o_entry_count       (o_entry_count),
    .o_lockout_remaining (o_lockout_remaining)
  );

  typedef struct {
    string       nm;
    logic        dv;
    logic [3:0]  d;
    logic        cf, sw, clr, rst;
    logic [2:0]  st;
    logic [1:0]  tr;
    logic [11:0] ent;
    logic [1:0]  cnt;
    logic        inc;
    logic [3:0]  lr;
  } step_t;

  step_t plan[$];
  step_t sb[$];

  function automatic void add(string nm, logic dv, logic [3:0] d, logic cf, logic sw,
                              logic clr, logic rst, logic [2:0] st, logic [1:0] tr,
                              logic [11:0] ent, logic [1:0] cnt, logic inc, logic [3:0] lr);
    step_t s;
    s.nm = nm; s.dv = dv; s.d = d; s.cf = cf; s.sw = sw; s.clr = clr; s.rst = rst;
    s.st = st; s.tr = tr; s.ent = ent; s.cnt = cnt; s.inc = inc; s.lr = lr;
    plan.push_back(s);
  endfunction

  task automatic apply(input step_t s);
    i_digit_valid = s.dv; i_digit = s.d; i_confirm = s.cf;
    i_switch = s.sw; i_clear = s.clr; i_reset = s.rst;
    sb.push_back(s);
    @(posedge clk); #1;
    i_digit_valid = 1'b0; i_digit = '0; i_confirm = 1'b0;
    i_switch = 1'b0; i_clear = 1'b0; i_reset = 1'b0;
  endtask

  task automatic test_reset();
    step_t e;
    logic cor;
    plan.delete();
    add("rst",  0, 0, 0, 0, 0, 1, 0, 3, 12'h000, 0, 0, 0);
    add("idle", 0, 0, 0, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    foreach (plan[i]) begin
      apply(plan[i]);
      e = sb.pop_front();
      cor = (e.st == 3'd1) || (e.st == 3'd2);
      compared++;
      if ({o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect, o_lockout_remaining}
          !== {e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr}) begin
        mismatched++;
        $display("FAIL reset/%s[%0d]: got st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d; want st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d",
                 e.nm, i, o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect,
                 o_lockout_remaining, e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr);
      end
    end
  endtask

  task automatic test_entry();
    step_t e;
    logic cor;
    plan.delete();
    add("d1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("d2",      1, 2, 0, 0, 0, 0, 0, 3, 12'h012, 2, 0, 0);
    add("d3",      1, 3, 0, 0, 0, 0, 0, 3, 12'h123, 3, 0, 0);
    add("open",    0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("relock",  0, 0, 1, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    add("p1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("p2",      1, 2, 0, 0, 0, 0, 0, 3, 12'h012, 2, 0, 0);
    add("partcf",  0, 0, 1, 0, 0, 0, 0, 3, 12'h012, 2, 0, 0);
    add("o9",      1, 9, 0, 0, 0, 0, 0, 3, 12'h129, 3, 0, 0);
    add("o1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h291, 3, 0, 0);
    add("o2",      1, 2, 0, 0, 0, 0, 0, 3, 12'h912, 3, 0, 0);
    add("o3",      1, 3, 0, 0, 0, 0, 0, 3, 12'h123, 3, 0, 0);
    add("ovopen",  0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("opendig", 1, 5, 0, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("relock2", 0, 0, 1, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    foreach (plan[i]) begin
      apply(plan[i]);
      e = sb.pop_front();
      cor = (e.st == 3'd1) || (e.st == 3'd2);
      compared++;
      if ({o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect, o_lockout_remaining}
          !== {e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr}) begin
        mismatched++;
        $display("FAIL entry/%s[%0d]: got st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d; want st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d",
                 e.nm, i, o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect,
                 o_lockout_remaining, e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr);
      end
    end
  endtask

  task automatic test_lockout_alarm();
    step_t e;
    logic cor;
    plan.delete();
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 3; a++) begin
        add("w4", 1, 4, 0, 0, 0, 0, 0, 2'(3 - a), 12'h004, 1, 0, 0);
        add("w5", 1, 5, 0, 0, 0, 0, 0, 2'(3 - a), 12'h045, 2, 0, 0);
        add("w6", 1, 6, 0, 0, 0, 0, 0, 2'(3 - a), 12'h456, 3, 0, 0);
        if (a < 2)       add("wcf",   0, 0, 1, 0, 0, 0, 0, 2'(2 - a), 12'h000, 0, 1, 0);
        else if (r == 0) add("lock",  0, 0, 1, 0, 0, 0, 3, 0, 12'h000, 0, 1, 8);
        else             add("alarm", 0, 0, 1, 0, 0, 0, 4, 0, 12'h000, 0, 1, 0);
      end
      if (r == 0) begin
        add("lo_cf",  0, 0, 1, 0, 0, 0, 3, 0, 12'h000, 0, 1, 7);
        add("lo_dig", 1, 1, 0, 0, 0, 0, 3, 0, 12'h000, 0, 1, 6);
        add("lo_clr", 0, 0, 0, 0, 1, 0, 3, 0, 12'h000, 0, 1, 5);
        for (int k = 4; k >= 1; k--) add("lo_cnt", 0, 0, 0, 0, 0, 0, 3, 0, 12'h000, 0, 1, 4'(k));
        add("lo_end", 0, 0, 0, 0, 0, 0, 0, 3, 12'h000, 0, 1, 0);
      end
    end
    add("al_d1",  1, 1, 0, 0, 0, 0, 4, 0, 12'h000, 0, 1, 0);
    add("al_d2",  1, 2, 0, 0, 0, 0, 4, 0, 12'h000, 0, 1, 0);
    add("al_d3",  1, 3, 0, 0, 0, 0, 4, 0, 12'h000, 0, 1, 0);
    add("al_cf",  0, 0, 1, 0, 0, 0, 4, 0, 12'h000, 0, 1, 0);
    add("al_clr", 0, 0, 0, 0, 1, 0, 4, 0, 12'h000, 0, 1, 0);
    add("al_sw",  0, 0, 0, 1, 0, 0, 4, 0, 12'h000, 0, 1, 0);
    add("al_rst", 0, 0, 0, 0, 0, 1, 0, 3, 12'h000, 0, 0, 0);
    add("r1",     1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("r2",     1, 2, 0, 0, 0, 0, 0, 3, 12'h012, 2, 0, 0);
    add("r3",     1, 3, 0, 0, 0, 0, 0, 3, 12'h123, 3, 0, 0);
    add("r_open", 0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("r_lock", 0, 0, 1, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    foreach (plan[i]) begin
      apply(plan[i]);
      e = sb.pop_front();
      cor = (e.st == 3'd1) || (e.st == 3'd2);
      compared++;
      if ({o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect, o_lockout_remaining}
          !== {e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr}) begin
        mismatched++;
        $display("FAIL lockout/%s[%0d]: got st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d; want st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d",
                 e.nm, i, o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect,
                 o_lockout_remaining, e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr);
      end
    end
  endtask

  task automatic test_password_change();
    step_t e;
    logic cor;
    plan.delete();
    add("a1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("a2",      1, 2, 0, 0, 0, 0, 0, 3, 12'h012, 2, 0, 0);
    add("a3",      1, 3, 0, 0, 0, 0, 0, 3, 12'h123, 3, 0, 0);
    add("open",    0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("sw",      0, 0, 0, 1, 0, 0, 2, 3, 12'h000, 0, 0, 0);
    add("n7",      1, 7, 0, 0, 0, 0, 2, 3, 12'h007, 1, 0, 0);
    add("n8",      1, 8, 0, 0, 0, 0, 2, 3, 12'h078, 2, 0, 0);
    add("partcf",  0, 0, 1, 0, 0, 0, 2, 3, 12'h078, 2, 0, 0);
    add("n9",      1, 9, 0, 0, 0, 0, 2, 3, 12'h789, 3, 0, 0);
    add("commit",  0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("relock",  0, 0, 1, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    add("o1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("o2",      1, 2, 0, 0, 0, 0, 0, 3, 12'h012, 2, 0, 0);
    add("o3",      1, 3, 0, 0, 0, 0, 0, 3, 12'h123, 3, 0, 0);
    add("oldrej",  0, 0, 1, 0, 0, 0, 0, 2, 12'h000, 0, 1, 0);
    add("m7",      1, 7, 0, 0, 0, 0, 0, 2, 12'h007, 1, 0, 0);
    add("m8",      1, 8, 0, 0, 0, 0, 0, 2, 12'h078, 2, 0, 0);
    add("m9",      1, 9, 0, 0, 0, 0, 0, 2, 12'h789, 3, 0, 0);
    add("newacc",  0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("sw2",     0, 0, 0, 1, 0, 0, 2, 3, 12'h000, 0, 0, 0);
    add("b1",      1, 1, 0, 0, 0, 0, 2, 3, 12'h001, 1, 0, 0);
    add("b2",      1, 2, 0, 0, 0, 0, 2, 3, 12'h012, 2, 0, 0);
    add("b3",      1, 3, 0, 0, 0, 0, 2, 3, 12'h123, 3, 0, 0);
    add("abort",   0, 0, 0, 1, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("relock2", 0, 0, 1, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    add("k7",      1, 7, 0, 0, 0, 0, 0, 3, 12'h007, 1, 0, 0);
    add("k8",      1, 8, 0, 0, 0, 0, 0, 3, 12'h078, 2, 0, 0);
    add("k9",      1, 9, 0, 0, 0, 0, 0, 3, 12'h789, 3, 0, 0);
    add("keptpw",  0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("relock3", 0, 0, 1, 0, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    foreach (plan[i]) begin
      apply(plan[i]);
      e = sb.pop_front();
      cor = (e.st == 3'd1) || (e.st == 3'd2);
      compared++;
      if ({o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect, o_lockout_remaining}
          !== {e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr}) begin
        mismatched++;
        $display("FAIL pwchange/%s[%0d]: got st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d; want st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d",
                 e.nm, i, o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect,
                 o_lockout_remaining, e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr);
      end
    end
  endtask

  task automatic test_simultaneity();
    step_t e;
    logic cor;
    plan.delete();
    add("c7",      1, 7, 0, 0, 0, 0, 0, 3, 12'h007, 1, 0, 0);
    add("c8",      1, 8, 0, 0, 0, 0, 0, 3, 12'h078, 2, 0, 0);
    add("c9",      1, 9, 0, 0, 0, 0, 0, 3, 12'h789, 3, 0, 0);
    add("clr+cf",  0, 0, 1, 0, 1, 0, 0, 3, 12'h000, 0, 0, 0);
    add("p1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("cf+dig",  1, 2, 1, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("sw+dig",  1, 3, 0, 1, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("clr+dig", 1, 4, 0, 0, 1, 0, 0, 3, 12'h000, 0, 0, 0);
    add("x1",      1, 1, 0, 0, 0, 0, 0, 3, 12'h001, 1, 0, 0);
    add("x2",      1, 1, 0, 0, 0, 0, 0, 3, 12'h011, 2, 0, 0);
    add("x3",      1, 1, 0, 0, 0, 0, 0, 3, 12'h111, 3, 0, 0);
    add("wrong",   0, 0, 1, 0, 0, 0, 0, 2, 12'h000, 0, 1, 0);
    add("clrinc",  0, 0, 0, 0, 1, 0, 0, 2, 12'h000, 0, 0, 0);
    add("g7",      1, 7, 0, 0, 0, 0, 0, 2, 12'h007, 1, 0, 0);
    add("g8",      1, 8, 0, 0, 0, 0, 0, 2, 12'h078, 2, 0, 0);
    add("g9",      1, 9, 0, 0, 0, 0, 0, 2, 12'h789, 3, 0, 0);
    add("open",    0, 0, 1, 0, 0, 0, 1, 3, 12'h000, 0, 0, 0);
    add("cf+sw",   0, 0, 1, 1, 0, 0, 0, 3, 12'h000, 0, 0, 0);
    foreach (plan[i]) begin
      apply(plan[i]);
      e = sb.pop_front();
      cor = (e.st == 3'd1) || (e.st == 3'd2);
      compared++;
      if ({o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect, o_lockout_remaining}
          !== {e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr}) begin
        mismatched++;
        $display("FAIL simul/%s[%0d]: got st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d; want st=%0d cor=%b tr=%0d ent=%h cnt=%0d inc=%b lr=%0d",
                 e.nm, i, o_state, o_correct, o_trials_left, o_entry, o_entry_count, o_incorrect,
                 o_lockout_remaining, e.st, cor, e.tr, e.ent, e.cnt, e.inc, e.lr);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_entry();
    test_lockout_alarm();
    test_password_change();
    test_simultaneity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
